// File: rtl/rx_frame_ctrl_if.sv
// PHY-to-FIFO receive bus for rx_frame_ctrl: PHY byte stream in, FIFO write/commit side out.
// master = PHY/FIFO side that drives the i_* signals, slave = the frame controller.
interface rx_frame_ctrl_if #(
  parameter int unsigned pDATA_W = 8,
  parameter int unsigned pFREE_W = 6
);
  logic               i_rx_dv;
  logic               i_rx_er;
  logic [pDATA_W-1:0] i_rx_data;
  logic [pFREE_W-1:0] i_free;
  logic               o_wr_en;
  logic [pDATA_W-1:0] o_wr_data;
  logic               o_commit;
  logic               o_abort;
  logic [10:0]        o_frame_len;
  logic               o_busy;
  logic [15:0]        o_drop_cnt;

  modport master (
    output i_rx_dv, i_rx_er, i_rx_data, i_free,
    input  o_wr_en, o_wr_data, o_commit, o_abort, o_frame_len, o_busy, o_drop_cnt
  );

  modport slave (
    input  i_rx_dv, i_rx_er, i_rx_data, i_free,
    output o_wr_en, o_wr_data, o_commit, o_abort, o_frame_len, o_busy, o_drop_cnt
  );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: strips preamble/SFD, writes payload to the port FIFO, then commits or
// aborts the frame. Define RX_LEN_CHECK_EN to enforce pMIN_LEN/pMAX_LEN frame length limits.
module rx_frame_ctrl #(
  parameter int unsigned pDATA_W  = 8,
  parameter int unsigned pFREE_W  = 6,
  parameter int unsigned pMIN_LEN = 64,
  parameter int unsigned pMAX_LEN = 1518
) (
  input  logic           i_clk_rx,
  input  logic           ireset,
  rx_frame_ctrl_if.slave rx_bus
);

  typedef enum logic [2:0] {
    StWaitIdle,
    StIdle,
    StPreamble,
    StData,
    StDrop,
    StEnd
  } state_e;

  localparam logic [pDATA_W-1:0] PreByte = pDATA_W'('h55);
  localparam logic [pDATA_W-1:0] SfdByte = pDATA_W'('hD5);

  if (pMIN_LEN > pMAX_LEN || pMAX_LEN > 2047) begin : g_bad_len_cfg
    $error("rx_frame_ctrl: pMIN_LEN/pMAX_LEN out of range");
  end

  state_e             state_q;
  logic               drop_q;
  logic               wr_en_q;
  logic [pDATA_W-1:0] wr_data_q;
  logic               commit_q;
  logic               abort_q;
  logic [10:0]        len_q;
  logic [15:0]        drop_cnt_q;

  logic        space_ok;
  logic        len_full;
  logic        abort_end;
  logic [10:0] len_inc;

  // i_free has not yet seen last cycle's write, so one extra entry must be free.
  assign space_ok = rx_bus.i_free > pFREE_W'(wr_en_q);
  assign len_inc  = (len_q == '1) ? len_q : len_q + 11'd1;

`ifdef RX_LEN_CHECK_EN
  assign len_full  = len_q >= 11'(pMAX_LEN);
  assign abort_end = drop_q || (len_q == '0) || (len_q < 11'(pMIN_LEN));
`else
  assign len_full  = 1'b0;
  assign abort_end = drop_q || (len_q == '0);
`endif

  always_ff @(posedge i_clk_rx) begin
    if (ireset) begin
      state_q    <= StWaitIdle;
      drop_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      commit_q   <= 1'b0;
      abort_q    <= 1'b0;
      len_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_en_q  <= 1'b0;
      commit_q <= 1'b0;
      abort_q  <= 1'b0;
      // Length stays visible alongside the commit/abort pulse, then clears.
      if (commit_q || abort_q) begin
        len_q <= '0;
      end

      unique case (state_q)
        StWaitIdle: begin
          if (!rx_bus.i_rx_dv) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (rx_bus.i_rx_dv) begin
            state_q <= (rx_bus.i_rx_data == PreByte) ? StPreamble : StWaitIdle;
          end
        end
        StPreamble: begin
          if (!rx_bus.i_rx_dv) begin
            state_q <= StIdle;
          end else if (rx_bus.i_rx_er) begin
            state_q <= StWaitIdle;
          end else if (rx_bus.i_rx_data == SfdByte) begin
            state_q <= StData;
          end else if (rx_bus.i_rx_data != PreByte) begin
            state_q <= StWaitIdle;
          end
        end
        StData: begin
          if (!rx_bus.i_rx_dv) begin
            state_q <= StEnd;
          end else if (rx_bus.i_rx_er || !space_ok || len_full) begin
            state_q <= StDrop;
            drop_q  <= 1'b1;
          end else begin
            wr_en_q   <= 1'b1;
            wr_data_q <= rx_bus.i_rx_data;
            len_q     <= len_inc;
          end
        end
        StDrop: begin
          if (!rx_bus.i_rx_dv) begin
            state_q <= StEnd;
          end
        end
        StEnd: begin
          state_q <= StIdle;
          drop_q  <= 1'b0;
          if (abort_end) begin
            abort_q <= 1'b1;
            if (drop_cnt_q != '1) begin
              drop_cnt_q <= drop_cnt_q + 16'd1;
            end
          end else begin
            commit_q <= 1'b1;
          end
        end
        default: state_q <= StWaitIdle;
      endcase
    end
  end

  assign rx_bus.o_wr_en     = wr_en_q;
  assign rx_bus.o_wr_data   = wr_data_q;
  assign rx_bus.o_commit    = commit_q;
  assign rx_bus.o_abort     = abort_q;
  assign rx_bus.o_frame_len = len_q;
  assign rx_bus.o_busy      = (state_q != StIdle) && (state_q != StWaitIdle);
  assign rx_bus.o_drop_cnt  = drop_cnt_q;

endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Receive-side frame controller for one switch port, in the `i_clk_rx` domain, between the PHY byte stream and the port's receive FIFO. It strips preamble and SFD and writes payload bytes into the FIFO. At end of frame it commits the frame (publishes the end pointer) or aborts it (rewinds the write pointer), so the transmit side only ever sees whole, error-free frames.

## Interface
- pDATA_W, 8, byte width of PHY and FIFO data
- pFREE_W, 6, width of FIFO free-entry count
- pMIN_LEN, 64, minimum legal frame length in bytes (SFD excluded)
- pMAX_LEN, 1518, maximum legal frame length in bytes
- i_clk_rx  in  1  PHY receive clock
- ireset  in  1  synchronous reset, active-high
- i_rx_dv  in  1  PHY data valid
- i_rx_er  in  1  PHY receive error
- i_rx_data  in  pDATA_W  PHY receive byte
- i_free  in  pFREE_W  free FIFO entries; lags `o_wr_en` by one cycle
- o_wr_en  out  1  FIFO write strobe
- o_wr_data  out  pDATA_W  FIFO write byte
- o_commit  out  1  one-cycle pulse: current frame good, publish end pointer
- o_abort  out  1  one-cycle pulse: discard current frame, rewind write pointer
- o_frame_len  out  11  byte count of the finished frame; valid with `o_commit` or `o_abort`
- o_busy  out  1  high in any state other than IDLE and WAIT_IDLE
- o_drop_cnt  out  16  saturating count of aborted frames

## Operation
- States are WAIT_IDLE, IDLE, PREAMBLE, DATA, DROP and END.
- Reset enters WAIT_IDLE. All outputs are 0 and the length register is 0.
- WAIT_IDLE: go to IDLE once `i_rx_dv` = 0 is sampled. This ignores the tail of any frame that was in progress at reset.
- IDLE: when `i_rx_dv` = 1 and `i_rx_data` = 0x55, go to PREAMBLE. When `i_rx_dv` = 1 and data is any other value, go to WAIT_IDLE.
- PREAMBLE:
  - 0x55: stay.
  - 0xD5 (SFD): go to DATA.
  - Any other byte, or `i_rx_er` = 1: go to WAIT_IDLE with no pulse, since nothing has been written.
  - `i_rx_dv` falls: go to IDLE with no pulse.
- DATA, each cycle with `i_rx_dv` = 1:
  - The byte is written only if `i_free` > (`o_wr_en` ? 1 : 0). This compensates for the one-cycle free-count lag.
  - On a write, `o_frame_len` is incremented; it saturates at 2047.
  - No space, or `i_rx_er` = 1: go to DROP without writing that byte.
- DATA, `i_rx_dv` = 0: go to END.
- DROP: no writes. Stay until `i_rx_dv` = 0, then go to END with the abort flag set.
- END (one cycle):
  - Pulse exactly one of `o_commit` or `o_abort`, then go to IDLE.
  - Abort if the drop flag is set or length = 0; otherwise commit.
  - `o_drop_cnt` increments on each abort and saturates at 0xFFFF.
  - The length register clears on the cycle after END.
- `o_commit` and `o_abort` are never high together. Neither is ever high in the same cycle as `o_wr_en`.

## Timing
- Write latency is 1 cycle: a byte sampled at edge n appears on `o_wr_en`/`o_wr_data` after edge n.
- `o_commit`/`o_abort` are high in the cycle after the first sampled `i_rx_dv` = 0. That is 2 cycles after the last write strobe.
- Minimum turnaround: a new preamble is accepted on the cycle after END.
- Back-to-back frames with a 1-cycle `i_rx_dv` gap must be handled correctly.
- Reset mid-frame drops `o_wr_en` the next cycle and emits no commit or abort. The FIFO's own reset clears its pointers.

## Configuration
- `RX_LEN_CHECK_EN` defined:
  - In DATA, once length would exceed `pMAX_LEN`, go to DROP without writing that byte.
  - In END, abort if length < `pMIN_LEN`.
- `RX_LEN_CHECK_EN` undefined:
  - No length limits; only error, overflow and zero-length frames abort.
  - Length still saturates at 2047; further bytes are still written while space exists.

## Test plan
- Reset, 7×0x55, 0xD5, 64 bytes 0x00..0x3F, `i_rx_dv` low, `i_free` = 32 with the FIFO drained -> 64 writes in order, then `o_commit` with `o_frame_len` = 64 two cycles after the last write, `o_drop_cnt` = 0.
- Same frame with `i_rx_er` = 1 on byte 10 -> exactly 10 writes, `o_abort` with `o_frame_len` = 10, `o_drop_cnt` = 1.
- `i_free` held at 3 and not drained -> 3 writes, then DROP, then `o_abort` with `o_frame_len` = 3.
- With `RX_LEN_CHECK_EN`, a 40-byte frame -> `o_abort` with `o_frame_len` = 40. Without the macro -> `o_commit` with 40.
- Preamble 0x55,0x55,0x12 -> no writes, no pulse. The next valid frame after `i_rx_dv` low commits normally.
- Assert `ireset` during byte 20 of a frame and release it with `i_rx_dv` still high -> no writes or pulses until `i_rx_dv` falls. The following frame commits.
